// File: rtl/rsa_cmp_arbiter_pkg.sv
// Shared definitions for the RSA comparator arbiter.
// Contents: FSM state encoding, requester limit, default operand width and the
// default watchdog limit derived from the operand word count.
package rsa_cmp_arbiter_pkg;

  // Largest supported requester count.
  localparam int unsigned NumReqMax        = 8;
  // Operand word width and words per operand.
  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned TotalAddr        = 16;
  // Longest WAIT before a compare is treated as all-equal and aborted.
  localparam int unsigned TimeoutDefault   = 2 * TotalAddr + 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGrant = 3'd1,
    StClr   = 3'd2,
    StStart = 3'd3,
    StWait  = 3'd4,
    StAbort = 3'd5,
    StDone  = 3'd6
  } state_e;

  // Width of a pointer that indexes n requesters.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsa_cmp_arbiter_if.sv
// Bundle of requester, operand-memory and comparator signals around the arbiter.
// Modports:
//   master - arbiter view: drives grants, done/result, memory reads and
//            comparator control/data.
//   slave  - environment view: requesters, operand memories and comparator.
interface rsa_cmp_arbiter_if
  import rsa_cmp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DataWidthDefault
) ();

  // Requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          result;
  logic                          eq;
  // Operand memories
  logic [NUM_REQ-1:0]            mem_r_en;
  logic [31:0]                   mem_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] mem_rdata1;
  logic [NUM_REQ*DATA_WIDTH-1:0] mem_rdata2;
  // Comparator side
  logic                          cmp_start;
  logic                          cmp_index_reset;
  logic                          cmp_r_en;
  logic [31:0]                   cmp_addr;
  logic [DATA_WIDTH-1:0]         cmp_rdata1;
  logic [DATA_WIDTH-1:0]         cmp_rdata2;
  logic                          cmp_result;
  logic                          cmp_ok;

  modport master (
    input  req, mem_rdata1, mem_rdata2, cmp_r_en, cmp_addr, cmp_result, cmp_ok,
    output gnt, done, result, eq, mem_r_en, mem_addr, cmp_start, cmp_index_reset,
           cmp_rdata1, cmp_rdata2
  );

  modport slave (
    output req, mem_rdata1, mem_rdata2, cmp_r_en, cmp_addr, cmp_result, cmp_ok,
    input  gnt, done, result, eq, mem_r_en, mem_addr, cmp_start, cmp_index_reset,
           cmp_rdata1, cmp_rdata2
  );

endinterface

// File: rtl/rsa_cmp_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_i - request vector
//   ptr_i - index that has highest priority this round
//   gnt_o - one-hot pick: first set request at or after ptr_i, wrapping
//   any_o - at least one request is set
module rsa_cmp_arbiter_rr_pick
  import rsa_cmp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] hi;
  logic [NUM_REQ-1:0] src;
  logic               found;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      mask[j] = (j >= int'(ptr_i));
    end
    hi    = req_i & mask;
    src   = (|hi) ? hi : req_i;
    gnt_o = '0;
    found = 1'b0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (src[j] && !found) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/rsa_cmp_arbiter.sv
// Shares one multi-word RSA magnitude comparator between NUM_REQ requesters.
// Round-robin grant, comparator index re-arm and start, read-bus routing to the
// granted requester's operand memories, and a watchdog that aborts compares of
// operands equal in every word by forcing a 1/0 word mismatch.
// Ports:
//   CLK, RST_N - clock, asynchronous active-low reset
//   bus        - rsa_cmp_arbiter_if.master (requesters, memories, comparator)
module rsa_cmp_arbiter
  import rsa_cmp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned TIMEOUT    = TimeoutDefault
) (
  input logic               CLK,
  input logic               RST_N,
  rsa_cmp_arbiter_if.master bus
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [WdW-1:0]     wdog_q, wdog_d;
  logic               result_q, result_d;
  logic               eq_q, eq_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic [PtrW-1:0]    ptr_next;

  rsa_cmp_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // Pointer moves to the slot after the requester being served.
  always_comb begin
    ptr_next = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (gnt_q[j]) begin
        ptr_next = (j == int'(NUM_REQ) - 1) ? '0 : PtrW'(j + 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    wdog_d   = wdog_q;
    result_d = result_q;
    eq_d     = eq_q;
    unique case (state_q)
      StIdle: begin
        // The pick is loaded on entry so gnt is already visible during GRANT.
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = StGrant;
        end
      end
      StGrant: state_d = StClr;
      StClr:   state_d = StStart;
      StStart: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + WdW'(1);
        if (bus.cmp_ok) begin
          result_d = bus.cmp_result;
          eq_d     = 1'b0;
          state_d  = StDone;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        // The comparator's verdict reflects the forced words, so drop it.
        if (bus.cmp_ok) begin
          result_d = 1'b0;
          eq_d     = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        ptr_d   = ptr_next;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      ptr_q    <= '0;
      wdog_q   <= '0;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      wdog_q   <= wdog_d;
      result_q <= result_d;
      eq_q     <= eq_d;
    end
  end

  logic [DATA_WIDTH-1:0] rdata1_mux;
  logic [DATA_WIDTH-1:0] rdata2_mux;

  always_comb begin
    rdata1_mux = '0;
    rdata2_mux = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (gnt_q[j]) begin
        rdata1_mux = rdata1_mux | bus.mem_rdata1[j*DATA_WIDTH +: DATA_WIDTH];
        rdata2_mux = rdata2_mux | bus.mem_rdata2[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state_q == StAbort) begin
      rdata1_mux = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      rdata2_mux = '0;
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.done            = (state_q == StDone) ? gnt_q : '0;
  assign bus.result          = result_q;
  assign bus.eq              = eq_q;
  assign bus.mem_addr        = bus.cmp_addr;
  assign bus.mem_r_en        = {NUM_REQ{bus.cmp_r_en}} & gnt_q;
  assign bus.cmp_start       = (state_q == StStart);
  assign bus.cmp_index_reset = (state_q == StClr);
  assign bus.cmp_rdata1      = rdata1_mux;
  assign bus.cmp_rdata2      = rdata2_mux;

endmodule

// File: tb/tb_rsa_cmp_arbiter.sv
// Directed bench for rsa_cmp_arbiter with a behavioural comparator and an
// expected-completion queue checked on every done pulse.
module tb_rsa_cmp_arbiter;
  import rsa_cmp_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_cmp_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(W)) bus ();

  rsa_cmp_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (W),
    .TIMEOUT    (TO)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   idx;
    logic res;
    logic eq;
  } exp_t;

  int       total = 0;
  int       bad = 0;
  int       done_cnt = 0;
  int       lat = 3;
  exp_t     sb[$];
  logic [W-1:0] d1 [NR];
  logic [W-1:0] d2 [NR];
  logic     ok_at_edge = 1'b0;

  always_comb begin
    bus.mem_rdata1 = '0;
    bus.mem_rdata2 = '0;
    for (int i = 0; i < NR; i++) begin
      bus.mem_rdata1[i*W +: W] = d1[i];
      bus.mem_rdata2[i*W +: W] = d2[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int i);
    exp_t e;
    e.idx = i;
    e.res = (d1[i] > d2[i]);
    e.eq  = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n;
    n = 0;
    while (!bus.cmp_start && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_start_seen"}, 64'(bus.cmp_start), 64'd1);
  endtask

  // Comparator model: after start, reads at 0x40 and finishes on the first
  // cycle at or past lat where the routed words differ; equal words never end.
  initial begin : cmp_model
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt  = 0;
    bus.cmp_ok     = 1'b0;
    bus.cmp_result = 1'b0;
    bus.cmp_r_en   = 1'b0;
    bus.cmp_addr   = '0;
    forever begin
      @(negedge clk);
      bus.cmp_ok = 1'b0;
      if (!rst_n) begin
        busy         = 1'b0;
        bus.cmp_r_en = 1'b0;
        bus.cmp_addr = '0;
      end else if (busy) begin
        cnt++;
        bus.cmp_r_en = 1'b1;
        bus.cmp_addr = 32'h40;
        if (cnt >= lat && bus.cmp_rdata1 != bus.cmp_rdata2) begin
          bus.cmp_ok     = 1'b1;
          bus.cmp_result = (bus.cmp_rdata1 > bus.cmp_rdata2);
          bus.cmp_r_en   = 1'b0;
          busy           = 1'b0;
        end
      end else if (bus.cmp_start) begin
        busy = 1'b1;
        cnt  = 0;
      end
    end
  end

  always @(posedge clk) ok_at_edge <= bus.cmp_ok;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_vec", 64'(bus.done), 64'(4'b0001 << e.idx));
          chk("done_result", 64'(bus.result), 64'(e.res));
          chk("done_eq", 64'(bus.eq), 64'(e.eq));
          chk("ok_to_done", 64'(ok_at_edge), 64'd1);
        end
        done_cnt++;
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int   base;
    int   c;
    exp_t e;
    bus.req = '0;
    for (int i = 0; i < NR; i++) begin
      d1[i] = 32'(10 * i + 1);
      d2[i] = 32'd15;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_eq", 64'(bus.eq), 64'd0);
    chk("rst_mem_r_en", 64'(bus.mem_r_en), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_start", 64'(bus.cmp_start), 64'd0);
    chk("rst_index_reset", 64'(bus.cmp_index_reset), 64'd0);
    chk("rst_rdata1", 64'(bus.cmp_rdata1), 64'd0);
    chk("rst_rdata2", 64'(bus.cmp_rdata2), 64'd0);
    rst_n = 1'b1;
    step();

    // Stray cmp_ok while idle is ignored
    bus.cmp_ok = 1'b1;
    step();
    step();
    chk("stray_ok_gnt", 64'(bus.gnt), 64'd0);
    chk("stray_ok_result", 64'(bus.result), 64'd0);

    // Contention from pointer 0: 0,1,2,3,0
    lat = 3;
    sb.push_back(mk(0));
    sb.push_back(mk(1));
    sb.push_back(mk(2));
    sb.push_back(mk(3));
    sb.push_back(mk(0));
    base = done_cnt;
    bus.req = 4'b1111;
    wait_done(base + 5, 200, "contention");
    bus.req = '0;
    step();
    step();
    chk("contention_idle_gnt", 64'(bus.gnt), 64'd0);

    // Read routing with requester 1
    d1[1] = 32'hA1B2C3D4;
    d2[1] = 32'h11223344;
    lat = 8;
    sb.push_back(mk(1));
    base = done_cnt;
    bus.req = 4'b0010;
    wait_start(20, "mux");
    repeat (3) step();
    chk("mux_gnt", 64'(bus.gnt), 64'h2);
    chk("mux_mem_addr", 64'(bus.mem_addr), 64'h40);
    chk("mux_mem_r_en", 64'(bus.mem_r_en), 64'h2);
    chk("mux_rdata1", 64'(bus.cmp_rdata1), 64'(d1[1]));
    chk("mux_rdata2", 64'(bus.cmp_rdata2), 64'(d2[1]));
    wait_done(base + 1, 50, "mux");
    bus.req = '0;
    step();

    // Single request latency
    d1[2] = 32'h30;
    d2[2] = 32'h20;
    lat = 10;
    sb.push_back(mk(2));
    base = done_cnt;
    bus.req = 4'b0100;
    step();
    chk("single_grant_gnt", 64'(bus.gnt), 64'h4);
    chk("single_grant_clr", 64'(bus.cmp_index_reset), 64'd0);
    step();
    chk("single_clr", 64'(bus.cmp_index_reset), 64'd1);
    chk("single_clr_start", 64'(bus.cmp_start), 64'd0);
    step();
    chk("single_start", 64'(bus.cmp_start), 64'd1);
    chk("single_start_clr", 64'(bus.cmp_index_reset), 64'd0);
    c = 0;
    while (done_cnt == base && c < 50) begin
      step();
      c++;
    end
    chk("single_start_to_done", 64'(c), 64'd11);
    bus.req = '0;
    step();

    // Equal operands: watchdog abort
    d1[0] = 32'h55;
    d2[0] = 32'h55;
    lat = 2;
    e.idx = 0;
    e.res = 1'b0;
    e.eq  = 1'b1;
    sb.push_back(e);
    base = done_cnt;
    bus.req = 4'b0001;
    wait_start(20, "equal");
    c = 0;
    while (done_cnt == base && c < TO + 10) begin
      step();
      c++;
      if (c == TO) begin
        chk("equal_wait_rdata1", 64'(bus.cmp_rdata1), 64'h55);
        chk("equal_wait_rdata2", 64'(bus.cmp_rdata2), 64'h55);
      end
      if (c == TO + 1) begin
        chk("abort_rdata1", 64'(bus.cmp_rdata1), 64'd1);
        chk("abort_rdata2", 64'(bus.cmp_rdata2), 64'd0);
      end
    end
    chk("equal_start_to_done", 64'(c), 64'(TO + 2));
    bus.req = '0;
    step();

    // Withdrawal during WAIT, then pointer must sit at 0
    d1[0] = 32'h7;
    d2[0] = 32'd15;
    d1[3] = 32'd31;
    lat = 6;
    sb.push_back(mk(3));
    base = done_cnt;
    bus.req = 4'b1000;
    wait_start(20, "withdraw");
    step();
    step();
    bus.req = '0;
    wait_done(base + 1, 50, "withdraw");
    step();
    sb.push_back(mk(0));
    sb.push_back(mk(3));
    base = done_cnt;
    bus.req = 4'b1001;
    wait_done(base + 1, 50, "after_withdraw_0");
    bus.req = 4'b1000;
    wait_done(base + 2, 50, "after_withdraw_3");
    bus.req = '0;
    step();
    step();

    // Reset in the middle of WAIT
    lat = 30;
    bus.req = 4'b0100;
    wait_start(20, "rst_mid");
    repeat (3) step();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_mid_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_start", 64'(bus.cmp_start), 64'd0);
    chk("rst_mid_clr", 64'(bus.cmp_index_reset), 64'd0);
    chk("rst_mid_mem_r_en", 64'(bus.mem_r_en), 64'd0);
    chk("rst_mid_result", 64'(bus.result), 64'd0);
    lat = 4;
    sb.push_back(mk(2));
    base = done_cnt;
    rst_n = 1'b1;
    step();
    chk("rst_restart_gnt", 64'(bus.gnt), 64'h4);
    chk("rst_restart_clr0", 64'(bus.cmp_index_reset), 64'd0);
    step();
    chk("rst_restart_clr1", 64'(bus.cmp_index_reset), 64'd1);
    wait_done(base + 1, 50, "rst_restart");
    bus.req = '0;
    step();
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_cmp_arbiter.md
Name: rsa_cmp_arbiter

Overview:
Shares one multi-word RSA magnitude comparator between NUM_REQ requesters, for example the modular-reduction and exponentiation sequencers. It selects requesters round-robin and re-arms the comparator's word index before each job. It routes the comparator's read bus to the granted requester's operand memories and returns the result with a one-cycle done pulse. A watchdog ends compares whose operands are equal in every word, which otherwise never finish.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, `DATA_WIDTH, operand word width (from _parameter.v)
TIMEOUT, 2*`TOTAL_ADDR+8, maximum WAIT cycles before abort

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request; held by requester until its done
gnt  out  NUM_REQ  one-hot grant, held from GRANT through DONE
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
result  out  1  1 = operand1 > operand2; valid while done is set
eq  out  1  operands equal (timeout); valid while done is set
mem_r_en  out  NUM_REQ  read enable; only the granted bit follows cmp_r_en
mem_addr  out  32  shared read address, equal to cmp_addr
mem_rdata1  in  NUM_REQ*DATA_WIDTH  flattened operand-1 read data
mem_rdata2  in  NUM_REQ*DATA_WIDTH  flattened operand-2 read data
cmp_start  out  1  compare start pulse
cmp_index_reset  out  1  comparator record-index reset pulse
cmp_r_en  in  1  comparator read enable
cmp_addr  in  32  comparator read address
cmp_rdata1  out  DATA_WIDTH  muxed operand-1 word to comparator
cmp_rdata2  out  DATA_WIDTH  muxed operand-2 word to comparator
cmp_result  in  1  comparator result
cmp_ok  in  1  comparator completion

Behaviour:
- Reset: every output is 0, FSM is in IDLE, round-robin pointer is 0, watchdog is 0.
- FSM states: IDLE, GRANT, CLR, START, WAIT, ABORT, DONE.
- IDLE: if any req is high, go to GRANT.
- GRANT: latch gnt to the first set req at or after the pointer, wrapping at NUM_REQ.
- CLR: cmp_index_reset=1 for one cycle.
- START: cmp_start=1 for one cycle; clear the watchdog.
- WAIT: increment the watchdog each cycle.
  - If cmp_ok: register result<=cmp_result, eq<=0, go to DONE.
  - Else if watchdog==TIMEOUT-1: go to ABORT.
- ABORT: force cmp_rdata1=1 and cmp_rdata2=0 so the comparator sees a mismatch and exits.
  - On cmp_ok: result<=0, eq<=1, go to DONE. The comparator's own result is discarded.
- DONE: done[g]=1 for one cycle; pointer<=g+1 (mod NUM_REQ); gnt clears on the next cycle; go to IDLE.
- Read routing (combinational): mem_addr=cmp_addr; mem_r_en[g]=cmp_r_en; all other mem_r_en bits are 0.
- Outside ABORT, cmp_rdata1/cmp_rdata2 come from the granted slice. With no grant they are 0.
- Latency: req to cmp_start is 3 cycles (GRANT, CLR, START). cmp_ok to done is 1 cycle.
- DONE, IDLE, GRANT and CLR give the comparator at least 2 cycles to return to its idle state before the next START.
- A req dropped mid-job is ignored: the job completes and done still pulses.
- A req held after done is treated as a new job. Fairness: each requester waits at most NUM_REQ-1 jobs.
- A new req arriving mid-job is only sampled in IDLE.
- cmp_ok outside WAIT/ABORT is ignored.
- Asserting RST_N mid-job returns everything to the reset state. No done is issued; the requester must re-request.
- Only one grant is live at a time; gnt is always one-hot or zero.

Decomposition:
- Shared package / _parameter.v holds:
  - FSM state encodings (3-bit)
  - NUM_REQ_MAX
  - TIMEOUT default, derived from `TOTAL_ADDR
- One sub-module, rr_pick: combinational round-robin selector (req, pointer -> one-hot, any).

Test Plan:
- Single request: req[2]=1; comparator model gives cmp_ok with cmp_result=1 after 10 cycles -> cmp_index_reset and cmp_start on cycles 2 and 3; done[2] one cycle after cmp_ok; result=1, eq=0.
- Contention: req=4'b1111 held, pointer 0 -> grants in order 0,1,2,3,0; never two gnt bits set.
- Read mux: gnt[1]; cmp_addr=0x40 with cmp_r_en=1 -> mem_addr=0x40 and mem_r_en=4'b0010; cmp_rdata1/2 match slice 1 of mem_rdata1/2.
- Equal operands: comparator model never raises cmp_ok until it sees a mismatch -> after TIMEOUT cycles, ABORT forces data 1/0; on cmp_ok, done pulses with eq=1, result=0.
- Withdrawal: req[3] drops during WAIT -> done[3] still pulses; pointer advances to 0.
- Reset mid-WAIT: RST_N low for 2 cycles -> gnt, done, cmp_start are 0 and FSM is IDLE; after release, a held req restarts at GRANT.
